// File: rtl/dc_uncached_bridge.sv
// Uncached D-cache responder: one posted write buffer, one bus transfer
// outstanding, read timeout returns poison and sets a sticky error flag.
module dc_uncached_bridge #(
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [63:0] POISON = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        valid,
  input  logic        req,
  input  logic [63:0] data_write,
  input  logic [63:0] wmask,
  input  logic [7:0]  wmask_uncacheble,
  output logic        ready,
  output logic [63:0] data_read,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_wstrb,
  input  logic        bus_rvalid,
  input  logic [63:0] bus_rdata,
  output logic        err_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LIM = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_ACK,
    RD_REQ,
    RD_WAIT,
    RD_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic          r_wb_full;
  logic [28:0]   r_wb_addr;
  logic [63:0]   r_wb_data;
  logic [7:0]    r_wb_strb;
  logic [TW-1:0] r_cnt;

  logic w_hs;
  logic w_expire;
  logic w_wr_acc;
  logic w_rd_acc;
  logic w_rd_bus;
  logic w_drain_go;
  logic w_unused;

  assign w_hs     = bus_valid & bus_ready;
  assign w_expire = (r_cnt == LIM);
  assign w_wr_acc = (r_state == IDLE) & valid
                  & req & ~r_wb_full;
  assign w_rd_acc = (r_state == IDLE) & valid
                  & ~req & ~r_wb_full;
  assign w_rd_bus = (r_state == RD_REQ)
                  | (r_state == RD_WAIT);
  // drain never competes with a read: reads only leave IDLE when empty
  assign w_drain_go = r_wb_full & ~bus_valid
                    & ~w_rd_bus;
  assign w_unused = ^{wmask, addr[2:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_wr_acc) begin
          w_next = WR_ACK;
        end else if (w_rd_acc) begin
          w_next = RD_REQ;
        end
      end
      WR_ACK:  w_next = IDLE;
      RD_REQ: begin
        if (w_hs) begin
          w_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (bus_rvalid || w_expire) begin
          w_next = RD_RESP;
        end
      end
      RD_RESP: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready       <= 1'b0;
      data_read   <= '0;
      err_timeout <= 1'b0;
      r_cnt       <= '0;
    end else begin
      ready <= (w_next == WR_ACK)
             | (w_next == RD_RESP);
      if (r_state == RD_REQ && w_hs) begin
        r_cnt <= '0;
      end else if (r_state == RD_WAIT) begin
        if (bus_rvalid) begin
          data_read <= bus_rdata;
        end else if (w_expire) begin
          data_read   <= POISON;
          err_timeout <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_full <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
      r_wb_strb <= '0;
    end else if (w_wr_acc) begin
      r_wb_full <= 1'b1;
      r_wb_addr <= addr[31:3];
      r_wb_data <= data_write;
      r_wb_strb <= wmask_uncacheble;
    end else if (w_hs && bus_we) begin
      r_wb_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
    end else if (w_hs) begin
      bus_valid <= 1'b0;
    end else if (w_drain_go) begin
      bus_valid <= 1'b1;
      bus_we    <= 1'b1;
      bus_addr  <= {r_wb_addr, 3'b000};
      bus_wdata <= r_wb_data;
      bus_wstrb <= r_wb_strb;
    end else if (r_state == RD_REQ
                 && !bus_valid) begin
      bus_valid <= 1'b1;
      bus_we    <= 1'b0;
      bus_addr  <= {addr[31:3], 3'b000};
    end
  end

endmodule

// File: tb/tb_dc_uncached_bridge.sv
// Directed bench for dc_uncached_bridge with a delay-programmable
// bus responder that logs every accepted bus transfer.
module tb_dc_uncached_bridge;

  localparam logic [63:0] POISON =
    64'hDEAD_BEEF_DEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic        valid = 1'b0;
  logic        req = 1'b0;
  logic [63:0] data_write = '0;
  logic [63:0] wmask = '0;
  logic [7:0]  wstrb_in = '0;
  logic        ready;
  logic [63:0] data_read;
  logic        bus_valid;
  logic        bus_ready = 1'b0;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_rvalid = 1'b0;
  logic [63:0] bus_rdata;
  logic        err_timeout;

  int          rdy_delay = 0;
  bit          rv_en = 1'b1;
  bit          force_rv = 1'b0;
  logic [63:0] rd_val = '0;
  bit          rv_pend = 1'b0;
  int          wcnt = 0;

  logic [31:0] lg_addr[$];
  logic        lg_we[$];
  logic [63:0] lg_data[$];
  logic [7:0]  lg_strb[$];

  int checks = 0;
  int errors = 0;
  int n;

  assign bus_rdata = rd_val;

  dc_uncached_bridge #(
    .TIMEOUT_CYCLES(8),
    .POISON(POISON)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .addr(addr),
    .valid(valid),
    .req(req),
    .data_write(data_write),
    .wmask(wmask),
    .wmask_uncacheble(wstrb_in),
    .ready(ready),
    .data_read(data_read),
    .bus_valid(bus_valid),
    .bus_ready(bus_ready),
    .bus_we(bus_we),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb),
    .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // responder acts on the falling edge; ready raised here is taken
  // by the DUT on the next rising edge, so the transfer is logged now
  always @(negedge clk) begin
    bus_ready  = 1'b0;
    bus_rvalid = rv_pend | force_rv;
    rv_pend    = 1'b0;
    if (bus_valid) begin
      if (wcnt >= rdy_delay) begin
        bus_ready = 1'b1;
        wcnt = 0;
        lg_addr.push_back(bus_addr);
        lg_we.push_back(bus_we);
        lg_data.push_back(bus_wdata);
        lg_strb.push_back(bus_wstrb);
        if (!bus_we && rv_en) rv_pend = 1'b1;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready(input int maxc,
                            output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!ready && cyc < maxc);
  endtask

  task automatic drive(input logic [31:0] a,
                       input logic r,
                       input logic [63:0] d,
                       input logic [7:0] s);
    addr       = a;
    req        = r;
    data_write = d;
    wstrb_in   = s;
    wmask      = {8{8'hFF}};
    valid      = 1'b1;
  endtask

  initial begin
    // reset and idle
    tick(2);
    rst_n = 1'b1;
    tick(10);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_bvalid", 64'(bus_valid), 64'd0);
    chk("rst_dread", data_read, 64'd0);
    chk("rst_err", 64'(err_timeout), 64'd0);
    chk("rst_baddr", 64'(bus_addr), 64'd0);

    // single posted write, bus_ready immediate
    drive(32'hA000_0004, 1'b1,
          64'h1122_3344_5566_7788, 8'hF0);
    tick(1);
    chk("w1_ready", 64'(ready), 64'd1);
    chk("w1_bv_early", 64'(bus_valid), 64'd0);
    valid = 1'b0;
    tick(1);
    chk("w1_ready_off", 64'(ready), 64'd0);
    chk("w1_bvalid", 64'(bus_valid), 64'd1);
    chk("w1_baddr", 64'(bus_addr), 64'hA000_0000);
    chk("w1_bwe", 64'(bus_we), 64'd1);
    chk("w1_bstrb", 64'(bus_wstrb), 64'hF0);
    chk("w1_bdata", bus_wdata,
        64'h1122_3344_5566_7788);
    tick(1);
    chk("w1_bv_drop", 64'(bus_valid), 64'd0);
    chk("w1_nlog", 64'(lg_addr.size()), 64'd1);

    // write then read, bus_ready delayed by 5
    rdy_delay = 5;
    rd_val = 64'hCAFE;
    drive(32'hA000_0010, 1'b1,
          64'h0102_0304_0506_0708, 8'h0F);
    tick(1);
    chk("w2_ready", 64'(ready), 64'd1);
    drive(32'hA000_0008, 1'b0, '0, '0);
    wait_ready(40, n);
    chk("r1_lat", 64'(n), 64'd16);
    chk("r1_after_rv", 64'(bus_rvalid), 64'd1);
    chk("r1_data", data_read, 64'hCAFE);
    valid = 1'b0;
    chk("r1_nlog", 64'(lg_addr.size()), 64'd3);
    chk("r1_log1_we", 64'(lg_we[1]), 64'd1);
    chk("r1_log1_a", 64'(lg_addr[1]), 64'hA000_0010);
    chk("r1_log2_we", 64'(lg_we[2]), 64'd0);
    chk("r1_log2_a", 64'(lg_addr[2]), 64'hA000_0008);
    tick(1);
    chk("r1_ready_off", 64'(ready), 64'd0);
    tick(2);

    // back-to-back writes, bus_ready delayed by 4
    rdy_delay = 4;
    drive(32'hB000_0000, 1'b1,
          64'hAAAA_0000_BBBB_1111, 8'hFF);
    tick(1);
    chk("bb1_ready", 64'(ready), 64'd1);
    drive(32'hB000_000C, 1'b1,
          64'hCCCC_2222_DDDD_3333, 8'h01);
    tick(1);
    chk("bb_stall", 64'(ready), 64'd0);
    wait_ready(30, n);
    chk("bb2_lat", 64'(n), 64'd6);
    chk("bb2_nlog", 64'(lg_addr.size()), 64'd4);
    valid = 1'b0;
    tick(8);
    chk("bb_nlog", 64'(lg_addr.size()), 64'd5);
    chk("bb_l3_a", 64'(lg_addr[3]), 64'hB000_0000);
    chk("bb_l3_d", lg_data[3], 64'hAAAA_0000_BBBB_1111);
    chk("bb_l4_a", 64'(lg_addr[4]), 64'hB000_0008);
    chk("bb_l4_d", lg_data[4], 64'hCCCC_2222_DDDD_3333);
    chk("bb_l4_s", 64'(lg_strb[4]), 64'h01);
    chk("bb_l4_we", 64'(lg_we[4]), 64'd1);

    // rvalid on the expiry cycle wins
    rdy_delay = 0;
    rv_en = 1'b0;
    rd_val = 64'h5555_AAAA_5555_AAAA;
    drive(32'hC000_0010, 1'b0, '0, '0);
    tick(10);
    chk("tie_early", 64'(ready), 64'd0);
    force_rv = 1'b1;
    tick(1);
    force_rv = 1'b0;
    chk("tie_ready", 64'(ready), 64'd1);
    chk("tie_data", data_read, 64'h5555_AAAA_5555_AAAA);
    chk("tie_err", 64'(err_timeout), 64'd0);
    valid = 1'b0;
    tick(2);

    // read timeout
    drive(32'hC000_0018, 1'b0, '0, '0);
    wait_ready(30, n);
    chk("to_lat", 64'(n), 64'd11);
    chk("to_data", data_read, POISON);
    chk("to_err", 64'(err_timeout), 64'd1);
    chk("to_baddr", 64'(lg_addr[lg_addr.size()-1]),
        64'hC000_0018);
    valid = 1'b0;
    tick(2);

    // good read at minimum latency, error stays sticky
    rv_en = 1'b1;
    rd_val = 64'h1234_5678_9ABC_DEF0;
    drive(32'hC000_0020, 1'b0, '0, '0);
    wait_ready(20, n);
    chk("min_lat", 64'(n), 64'd4);
    chk("min_data", data_read, 64'h1234_5678_9ABC_DEF0);
    chk("sticky_err", 64'(err_timeout), 64'd1);
    valid = 1'b0;
    tick(2);

    // reset while waiting for read data
    rv_en = 1'b0;
    drive(32'hD000_0000, 1'b0, '0, '0);
    tick(4);
    rst_n = 1'b0;
    valid = 1'b0;
    #1;
    chk("mr_ready", 64'(ready), 64'd0);
    chk("mr_bvalid", 64'(bus_valid), 64'd0);
    chk("mr_dread", data_read, 64'd0);
    chk("mr_err", 64'(err_timeout), 64'd0);
    chk("mr_baddr", 64'(bus_addr), 64'd0);
    tick(1);
    rst_n = 1'b1;
    force_rv = 1'b1;
    tick(1);
    force_rv = 1'b0;
    chk("mr_rv_ign", 64'(ready), 64'd0);
    chk("mr_rv_data", data_read, 64'd0);
    tick(2);
    chk("mr_idle", 64'(bus_valid), 64'd0);
    rv_en = 1'b1;
    rd_val = 64'hFEED_FACE_0BAD_C0DE;
    drive(32'hE000_0008, 1'b0, '0, '0);
    wait_ready(20, n);
    chk("mr_rd_lat", 64'(n), 64'd4);
    chk("mr_rd_data", data_read, 64'hFEED_FACE_0BAD_C0DE);
    valid = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
